data_mem_controller: RTL and testbench

- Responder side of the per-thread load/store memory handshake: accepts read and write requests from NUM_CONSUMERS thread LSUs.
- Arbitrates those requests onto NUM_CHANNELS external data-memory channels and relays responses back to the requesting LSU.
- Sits between all core LSUs and the data memory interface.

---
 rtl/data_mem_controller.sv | 179 +++++++++++++++++
 tb/tb_data_mem_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// Data memory controller: arbitrates per-LSU load/store requests onto
// NUM_CHANNELS external memory channels with fixed lowest-index priority.
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam bit WE = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                           state_q [NUM_CHANNELS];
  state_t                           state_d [NUM_CHANNELS];
  logic [CW-1:0]                    owner_q [NUM_CHANNELS];
  logic [CW-1:0]                    owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]         claim_q, claim_d, taken;
  logic [NUM_CONSUMERS-1:0]         c_rd_ready_q, c_rd_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] c_rd_data_q, c_rd_data_d;
  logic [NUM_CONSUMERS-1:0]         c_wr_ready_q, c_wr_ready_d;
  logic [NUM_CHANNELS-1:0]          m_rd_valid_q, m_rd_valid_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] m_rd_addr_q, m_rd_addr_d;
  logic [NUM_CHANNELS-1:0]          m_wr_valid_q, m_wr_valid_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] m_wr_addr_q, m_wr_addr_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] m_wr_data_q, m_wr_data_d;
  logic                             found, sel_write;
  logic [CW-1:0]                    sel;

  // Channels are walked in ascending order; 'taken' carries both standing
  // claims and claims made by lower channels this cycle. Releases only touch
  // claim_d, so a released consumer is not re-selected until the next cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    claim_d      = claim_q;
    taken        = claim_q;
    c_rd_ready_d = c_rd_ready_q;
    c_rd_data_d  = c_rd_data_q;
    c_wr_ready_d = c_wr_ready_q;
    m_rd_valid_d = m_rd_valid_q;
    m_rd_addr_d  = m_rd_addr_q;
    m_wr_valid_d = m_wr_valid_q;
    m_wr_addr_d  = m_wr_addr_q;
    m_wr_data_d  = m_wr_data_q;
    found        = 1'b0;
    sel_write    = 1'b0;
    sel          = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found     = 1'b0;
      sel_write = 1'b0;
      sel       = '0;
      case (state_q[ch])
        IDLE: begin
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!found && !taken[c] &&
                (consumer_read_valid[c] || (WE && consumer_write_valid[c]))) begin
              found     = 1'b1;
              sel       = CW'(c);
              sel_write = !consumer_read_valid[c];
            end
          end
          if (found) begin
            taken[sel]   = 1'b1;
            claim_d[sel] = 1'b1;
            owner_d[ch]  = sel;
            if (sel_write) begin
              m_wr_valid_d[ch] = 1'b1;
              m_wr_addr_d[ch*ADDR_BITS +: ADDR_BITS] =
                consumer_write_address[int'(sel)*ADDR_BITS +: ADDR_BITS];
              m_wr_data_d[ch*DATA_BITS +: DATA_BITS] =
                consumer_write_data[int'(sel)*DATA_BITS +: DATA_BITS];
              state_d[ch] = WRITE_WAITING;
            end else begin
              m_rd_valid_d[ch] = 1'b1;
              m_rd_addr_d[ch*ADDR_BITS +: ADDR_BITS] =
                consumer_read_address[int'(sel)*ADDR_BITS +: ADDR_BITS];
              state_d[ch] = READ_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            m_rd_valid_d[ch]          = 1'b0;
            c_rd_ready_d[owner_q[ch]] = 1'b1;
            c_rd_data_d[int'(owner_q[ch])*DATA_BITS +: DATA_BITS] =
              mem_read_data[ch*DATA_BITS +: DATA_BITS];
            state_d[ch] = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            m_wr_valid_d[ch]          = 1'b0;
            c_wr_ready_d[owner_q[ch]] = 1'b1;
            state_d[ch]               = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            c_rd_ready_d[owner_q[ch]] = 1'b0;
            claim_d[owner_q[ch]]      = 1'b0;
            state_d[ch]               = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[owner_q[ch]]) begin
            c_wr_ready_d[owner_q[ch]] = 1'b0;
            claim_d[owner_q[ch]]      = 1'b0;
            state_d[ch]               = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
      end
      claim_q      <= '0;
      c_rd_ready_q <= '0;
      c_rd_data_q  <= '0;
      c_wr_ready_q <= '0;
      m_rd_valid_q <= '0;
      m_rd_addr_q  <= '0;
      m_wr_valid_q <= '0;
      m_wr_addr_q  <= '0;
      m_wr_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      claim_q      <= claim_d;
      c_rd_ready_q <= c_rd_ready_d;
      c_rd_data_q  <= c_rd_data_d;
      c_wr_ready_q <= c_wr_ready_d;
      m_rd_valid_q <= m_rd_valid_d;
      m_rd_addr_q  <= m_rd_addr_d;
      m_wr_valid_q <= m_wr_valid_d;
      m_wr_addr_q  <= m_wr_addr_d;
      m_wr_data_q  <= m_wr_data_d;
    end
  end

  assign consumer_read_ready  = c_rd_ready_q;
  assign consumer_read_data   = c_rd_data_q;
  assign mem_read_valid       = m_rd_valid_q;
  assign mem_read_address     = m_rd_addr_q;
  assign consumer_write_ready = WE ? c_wr_ready_q : '0;
  assign mem_write_valid      = WE ? m_wr_valid_q : '0;
  assign mem_write_address    = WE ? m_wr_addr_q  : '0;
  assign mem_write_data       = WE ? m_wr_data_q  : '0;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed testbench for data_mem_controller: a 1-channel and a 2-channel
// instance share clock, reset and consumer-side stimulus.
`timescale 1ns/1ps
module tb_data_mem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  crv, cwv;
  logic [31:0] cra, cwa, cwd;
  logic [3:0]  crr, cwr, crr2, cwr2;
  logic [31:0] crd, crd2;

  logic        mrv, mrr, mwv, mwr;
  logic [7:0]  mra, mrd, mwa, mwd;
  logic [1:0]  mrv2, mrr2, mwv2, mwr2;
  logic [15:0] mra2, mrd2, mwa2, mwd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_controller #(.NUM_CHANNELS(1)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  data_mem_controller #(.NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr2), .consumer_read_data(crd2),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr2),
    .mem_read_valid(mrv2), .mem_read_address(mra2),
    .mem_read_ready(mrr2), .mem_read_data(mrd2),
    .mem_write_valid(mwv2), .mem_write_address(mwa2),
    .mem_write_data(mwd2), .mem_write_ready(mwr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = 1'b0; mrd = '0; mwr = 1'b0;
    mrr2 = '0; mrd2 = '0; mwr2 = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({crr, cwr, crd, mrv, mwv, mra, mwa, mwd} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected 0",
               {crr, cwr, crd, mrv, mwv, mra, mwa, mwd});
    end
    checks++;
    if ({crr2, cwr2, crd2, mrv2, mwv2, mra2, mwa2, mwd2} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_2ch got %h expected 0",
               {crr2, cwr2, crd2, mrv2, mwv2, mra2, mwa2, mwd2});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    crv[2] = 1'b1; cra[23:16] = 8'h1A;
    tick();
    checks++;
    if ({mrv, mra} !== {1'b1, 8'h1A}) begin
      errors++;
      $display("[TB] FAIL read_issue got v=%b a=%h expected v=1 a=1a", mrv, mra);
    end
    tick();
    mrr = 1'b1; mrd = 8'h5C;
    tick();
    mrr = 1'b0;
    checks++;
    if ({crr, crd[23:16], mrv} !== {4'b0100, 8'h5C, 1'b0}) begin
      errors++;
      $display("[TB] FAIL read_response got rdy=%b d=%h mv=%b expected rdy=0100 d=5c mv=0",
               crr, crd[23:16], mrv);
    end
    crv[2] = 1'b0;
    tick();
    checks++;
    if ({crr, crd[23:16]} !== {4'b0000, 8'h5C}) begin
      errors++;
      $display("[TB] FAIL read_release got rdy=%b d=%h expected rdy=0000 d=5c",
               crr, crd[23:16]);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    cwv[0] = 1'b1; cwa[7:0] = 8'h03; cwd[7:0] = 8'hAA;
    tick();
    checks++;
    if ({mwv, mwa, mwd, mrv} !== {1'b1, 8'h03, 8'hAA, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_issue got v=%b a=%h d=%h rv=%b expected v=1 a=03 d=aa rv=0",
               mwv, mwa, mwd, mrv);
    end
    mwr = 1'b1;
    tick();
    mwr = 1'b0;
    checks++;
    if ({cwr, mwv, mrv} !== {4'b0001, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_ack got wr=%b mwv=%b rv=%b expected wr=0001 mwv=0 rv=0",
               cwr, mwv, mrv);
    end
    cwv[0] = 1'b0;
    tick();
    checks++;
    if ({cwr, mrv, mwv} !== '0) begin
      errors++;
      $display("[TB] FAIL write_release got wr=%b rv=%b mwv=%b expected all 0", cwr, mrv, mwv);
    end
  endtask

  task automatic test_contention();
    do_reset();
    crv = 4'b1010; cra[15:8] = 8'h11; cra[31:24] = 8'h33;
    tick();
    checks++;
    if ({mrv, mra} !== {1'b1, 8'h11}) begin
      errors++;
      $display("[TB] FAIL contention_first got v=%b a=%h expected v=1 a=11", mrv, mra);
    end
    mrr = 1'b1; mrd = 8'h71;
    tick();
    mrr = 1'b0;
    checks++;
    if ({crr, crd[15:8]} !== {4'b0010, 8'h71}) begin
      errors++;
      $display("[TB] FAIL contention_resp1 got rdy=%b d=%h expected rdy=0010 d=71", crr, crd[15:8]);
    end
    crv[1] = 1'b0;
    tick();
    checks++;
    if ({crr, mrv} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL contention_gap got rdy=%b v=%b expected rdy=0000 v=0", crr, mrv);
    end
    tick();
    checks++;
    if ({mrv, mra} !== {1'b1, 8'h33}) begin
      errors++;
      $display("[TB] FAIL contention_second got v=%b a=%h expected v=1 a=33", mrv, mra);
    end
    mrr = 1'b1; mrd = 8'h73;
    tick();
    mrr = 1'b0;
    checks++;
    if ({crr, crd[31:24], crd[15:8]} !== {4'b1000, 8'h73, 8'h71}) begin
      errors++;
      $display("[TB] FAIL contention_resp3 got rdy=%b d3=%h d1=%h expected rdy=1000 d3=73 d1=71",
               crr, crd[31:24], crd[15:8]);
    end
    crv = '0;
  endtask

  task automatic test_read_priority();
    do_reset();
    crv[1] = 1'b1; cwv[1] = 1'b1; cra[15:8] = 8'h55; cwa[15:8] = 8'h66; cwd[15:8] = 8'h77;
    tick();
    checks++;
    if ({mrv, mra, mwv} !== {1'b1, 8'h55, 1'b0}) begin
      errors++;
      $display("[TB] FAIL priority_read got rv=%b a=%h wv=%b expected rv=1 a=55 wv=0", mrv, mra, mwv);
    end
    mrr = 1'b1; mrd = 8'h01;
    tick();
    mrr = 1'b0;
    crv[1] = 1'b0;
    tick();
    tick();
    checks++;
    if ({mwv, mwa, mwd, mrv} !== {1'b1, 8'h66, 8'h77, 1'b0}) begin
      errors++;
      $display("[TB] FAIL priority_write got wv=%b a=%h d=%h rv=%b expected wv=1 a=66 d=77 rv=0",
               mwv, mwa, mwd, mrv);
    end
    cwv = '0;
  endtask

  task automatic test_hold();
    do_reset();
    crv[0] = 1'b1; cra[7:0] = 8'h40;
    tick();
    mrr = 1'b1; mrd = 8'h99;
    tick();
    // Late memory ready with different data must not disturb the relay
    mrd = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({crr, crd[7:0], mrv} !== {4'b0001, 8'h99, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d got rdy=%b d=%h mv=%b expected rdy=0001 d=99 mv=0",
                 i, crr, crd[7:0], mrv);
      end
      tick();
    end
    mrr = 1'b0;
    crv[0] = 1'b0;
    tick();
    checks++;
    if ({crr, crd[7:0]} !== {4'b0000, 8'h99}) begin
      errors++;
      $display("[TB] FAIL hold_release got rdy=%b d=%h expected rdy=0000 d=99", crr, crd[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    crv[0] = 1'b1; cra[7:0] = 8'h42;
    tick();
    checks++;
    if (mrv !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_issue got v=%b expected 1", mrv);
    end
    reset = 1'b0; crv = '0;
    tick();
    checks++;
    if ({crr, mrv, mra} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_clear got rdy=%b v=%b a=%h expected 0", crr, mrv, mra);
    end
    reset = 1'b1;
    mrr = 1'b1; mrd = 8'h12;
    tick();
    tick();
    mrr = 1'b0;
    checks++;
    if ({crr, crd, mrv} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_late_ready got rdy=%b d=%h v=%b expected 0", crr, crd, mrv);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    crv = 4'b0011; cra[7:0] = 8'h20; cra[15:8] = 8'h21;
    tick();
    checks++;
    if ({mrv2, mra2} !== {2'b11, 8'h21, 8'h20}) begin
      errors++;
      $display("[TB] FAIL parallel_issue got v=%b a=%h expected v=11 a=2120", mrv2, mra2);
    end
    mrr2 = 2'b11; mrd2 = {8'hB1, 8'hB0};
    tick();
    mrr2 = '0;
    checks++;
    if ({crr2, crd2[15:0], mrv2} !== {4'b0011, 8'hB1, 8'hB0, 2'b00}) begin
      errors++;
      $display("[TB] FAIL parallel_resp got rdy=%b d=%h v=%b expected rdy=0011 d=b1b0 v=00",
               crr2, crd2[15:0], mrv2);
    end
    crv = '0;
    tick();
    checks++;
    if ({crr2, mrv2} !== '0) begin
      errors++;
      $display("[TB] FAIL parallel_release got rdy=%b v=%b expected 0", crr2, mrv2);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_read_priority();
    test_hold();
    test_reset_mid();
    test_parallel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
